// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: memory-stage inputs, pipeline control and writeback outputs.
//   master : MEM-stage side, drives EX_MEM_* fields, load data and stall/flush/clear
//   slave  : the MEM/WB register, drives MEM_WB_* fields and the retire count
interface mem_wb_stage_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic                MEM_Stall;
    logic                MEM_Flush;
    logic                EX_MEM_Valid;
    logic [DATA_W-1:0]   EX_MEM_ALUResult;
    logic [DATA_W-1:0]   MEM_ReadData;
    logic                EX_MEM_MemToReg;
    logic                EX_MEM_RegWrite;
    logic [REG_W-1:0]    EX_MEM_WriteReg;
    logic                WB_CountClr;
    logic [DATA_W-1:0]   MEM_WB_WriteData;
    logic [REG_W-1:0]    MEM_WB_WriteReg;
    logic                MEM_WB_RegWrite;
    logic                MEM_WB_Valid;
    logic [DATA_W-1:0]   MEM_WB_ALUResult;
    logic [DATA_W-1:0]   WB_RetireCount;

    modport master (
        output MEM_Stall, MEM_Flush, EX_MEM_Valid, EX_MEM_ALUResult, MEM_ReadData,
               EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_WriteReg, WB_CountClr,
        input  MEM_WB_WriteData, MEM_WB_WriteReg, MEM_WB_RegWrite, MEM_WB_Valid,
               MEM_WB_ALUResult, WB_RetireCount
    );

    modport slave (
        input  MEM_Stall, MEM_Flush, EX_MEM_Valid, EX_MEM_ALUResult, MEM_ReadData,
               EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_WriteReg, WB_CountClr,
        output MEM_WB_WriteData, MEM_WB_WriteReg, MEM_WB_RegWrite, MEM_WB_Valid,
               MEM_WB_ALUResult, WB_RetireCount
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback data select, stall (hold) and flush (bubble).
// Ports:
//   Clk  - core clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - mem_wb_stage_if.slave: EX_MEM_* / MEM_ReadData / stall / flush / count-clear in,
//          MEM_WB_WriteData/WriteReg/RegWrite/Valid/ALUResult and WB_RetireCount out
// Build option: define MEMWB_RETIRE_CNT_EN to build the retired-instruction counter;
// otherwise WB_RetireCount is tied to zero and WB_CountClr is ignored.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input logic          Clk,
    input logic          Rst,
    mem_wb_stage_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    // Slot occupancy; MEM_WB_Valid is the state itself
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q,  state_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [REG_W-1:0]  wreg_q,   wreg_d;
    logic              regwr_q,  regwr_d;
    logic [DATA_W-1:0] alures_q, alures_d;
    logic              capture_c;

    // Flush beats stall; a plain capture only happens with neither asserted
    assign capture_c = !bus.MEM_Flush && !bus.MEM_Stall;

    // Next-state / next-data selection
    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        wreg_d   = wreg_q;
        regwr_d  = regwr_q;
        alures_d = alures_q;
        if (bus.MEM_Flush) begin
            state_d  = ST_EMPTY;
            wdata_d  = '0;
            wreg_d   = '0;
            regwr_d  = 1'b0;
            alures_d = '0;
        end else if (capture_c) begin
            state_d  = bus.EX_MEM_Valid ? ST_FULL : ST_EMPTY;
            wdata_d  = bus.EX_MEM_MemToReg ? bus.MEM_ReadData : bus.EX_MEM_ALUResult;
            wreg_d   = bus.EX_MEM_WriteReg;
            alures_d = bus.EX_MEM_ALUResult;
            // $zero is never written, so the enable is suppressed here rather than in the RF
            regwr_d  = bus.EX_MEM_RegWrite && bus.EX_MEM_Valid &&
                       (bus.EX_MEM_WriteReg != REG_W'(0));
        end
    end

    // Pipeline register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= ST_EMPTY;
            wdata_q  <= '0;
            wreg_q   <= '0;
            regwr_q  <= 1'b0;
            alures_q <= RESET_PC_TAG;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            wreg_q   <= wreg_d;
            regwr_q  <= regwr_d;
            alures_q <= alures_d;
        end
    end

    assign bus.MEM_WB_WriteData = wdata_q;
    assign bus.MEM_WB_WriteReg  = wreg_q;
    assign bus.MEM_WB_RegWrite  = regwr_q;
    assign bus.MEM_WB_Valid     = (state_q == ST_FULL);
    assign bus.MEM_WB_ALUResult = alures_q;

`ifdef MEMWB_RETIRE_CNT_EN
    logic [DATA_W-1:0] cnt_q;

    // Retire counter: clear wins, works under stall/flush; wraps naturally
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else if (bus.WB_CountClr) begin
            cnt_q <= '0;
        end else if (capture_c && bus.EX_MEM_Valid) begin
            cnt_q <= cnt_q + DATA_W'(1);
        end
    end

    assign bus.WB_RetireCount = cnt_q;
`else
    logic unused_count_clr;
    assign unused_count_clr   = bus.WB_CountClr;
    assign bus.WB_RetireCount = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic,
// checked against a rule-level reference model. Honors MEMWB_RETIRE_CNT_EN.
module tb_mem_wb_stage;
    localparam logic [31:0] TAG = 32'hCAFE_0040;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state
    logic [31:0] e_wd, e_alu, e_cnt;
    logic [4:0]  e_wr;
    logic        e_rw, e_v;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.RESET_PC_TAG(TAG)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [134:0] got_vec();
        return {bus.MEM_WB_WriteData, bus.MEM_WB_WriteReg, bus.MEM_WB_RegWrite,
                bus.MEM_WB_Valid, bus.MEM_WB_ALUResult, bus.WB_RetireCount};
    endfunction

    function automatic logic [134:0] exp_vec();
        return {e_wd, e_wr, e_rw, e_v, e_alu, e_cnt};
    endfunction

    task automatic model_reset();
        e_wd = '0; e_wr = '0; e_rw = 1'b0; e_v = 1'b0; e_alu = TAG; e_cnt = '0;
    endtask

    // What one rising edge does, straight from the pipeline-register rules
    task automatic model_edge();
        logic normal;
        if (!Rst) begin
            model_reset();
            return;
        end
        normal = !bus.MEM_Flush && !bus.MEM_Stall;
        if (bus.MEM_Flush) begin
            e_v = 1'b0; e_rw = 1'b0; e_wd = '0; e_wr = '0; e_alu = '0;
        end else if (normal) begin
            e_wd  = bus.EX_MEM_MemToReg ? bus.MEM_ReadData : bus.EX_MEM_ALUResult;
            e_wr  = bus.EX_MEM_WriteReg;
            e_alu = bus.EX_MEM_ALUResult;
            e_v   = bus.EX_MEM_Valid;
            e_rw  = bus.EX_MEM_RegWrite && bus.EX_MEM_Valid && (bus.EX_MEM_WriteReg != 5'd0);
        end
`ifdef MEMWB_RETIRE_CNT_EN
        if (bus.WB_CountClr) e_cnt = '0;
        else if (normal && bus.EX_MEM_Valid) e_cnt = e_cnt + 32'd1;
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                         input logic m2r, input logic rw, input logic [4:0] wr,
                         input logic stall, input logic flush, input logic clr);
        bus.EX_MEM_Valid = v; bus.EX_MEM_ALUResult = alu; bus.MEM_ReadData = rd;
        bus.EX_MEM_MemToReg = m2r; bus.EX_MEM_RegWrite = rw; bus.EX_MEM_WriteReg = wr;
        bus.MEM_Stall = stall; bus.MEM_Flush = flush; bus.WB_CountClr = clr;
    endtask

    task automatic drive_rand(input int stall_pct, input int flush_pct, input int clr_pct);
        logic [4:0] wr;
        wr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        drive(1'($urandom_range(3) != 0), $urandom, $urandom, 1'($urandom), 1'($urandom), wr,
              1'($urandom_range(99) < stall_pct), 1'($urandom_range(99) < flush_pct),
              1'($urandom_range(99) < clr_pct));
    endtask

    // Advance one edge, update the model, settle past the edge
    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_rand(30, 30, 30);
            tick();
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        Rst = 1'b1;
    endtask

    task automatic test_alu_load();
        drive(1'b1, 32'h0000_1234, 32'h5555_AAAA, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_WriteData !== 32'h1234 ||
            bus.MEM_WB_WriteReg !== 5'd5 || bus.MEM_WB_RegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_path: got %h want %h", got_vec(), exp_vec());
        end
        drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_WriteData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL load_path: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 32'h0000_0077, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_RegWrite !== 1'b0 ||
            bus.MEM_WB_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_reg: got %h want %h", got_vec(), exp_vec());
        end
        // Invalid slot with RegWrite set must not write either
        drive(1'b0, 32'h0000_0088, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_RegWrite !== 1'b0 ||
            bus.MEM_WB_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_in: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] cnt0;
        drive(1'b1, 32'h0000_0700, 32'h0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        cnt0 = e_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, 5'(i + 10), 1'b1, 1'b0, 1'b0);
            tick();
            vectors++;
            if (got_vec() !== exp_vec() || bus.MEM_WB_WriteReg !== 5'd7 ||
                bus.WB_RetireCount !== cnt0) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
        drive(1'b1, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_Valid !== 1'b0 ||
            bus.MEM_WB_RegWrite !== 1'b0 || bus.MEM_WB_WriteData !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_stall: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_counter();
`ifdef MEMWB_RETIRE_CNT_EN
        dut.cnt_q = 32'hFFFF_FFFF;
        e_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.WB_RetireCount !== 32'h0) begin
            miscompares++;
            $display("FAIL cnt_wrap: got %h want %h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h0000_0002, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.WB_RetireCount !== 32'h0) begin
            miscompares++;
            $display("FAIL cnt_clear: got %h want %h", got_vec(), exp_vec());
        end
`else
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, 5'(i + 1), 1'b0, 1'b0,
                  1'($urandom));
            tick();
            vectors++;
            if (got_vec() !== exp_vec() || bus.WB_RetireCount !== 32'h0) begin
                miscompares++;
                $display("FAIL cnt_tied[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_rand(25, 10, 5);
            tick();
            vectors++;
            if (got_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1357_9BDF, 32'h0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (got_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", got_vec(), exp_vec());
        end
        tick();
        vectors++;
        if (got_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", got_vec(), exp_vec());
        end
        // Release mid-cycle; first capture lands on the next rising edge
        #2;
        Rst = 1'b1;
        drive(1'b1, 32'h2468_ACE0, 32'h0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (got_vec() !== exp_vec() || bus.MEM_WB_WriteReg !== 5'd8) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", got_vec(), exp_vec());
        end
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu_load();
        test_zero_reg();
        test_stall_flush();
        test_counter();
        test_random();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback select for each processor core. It captures the memory stage's ALU result, load data and destination controls on every clock, then presents the register-file write port (data, register index, enable) to the WB stage and the forwarding unit. It supports pipeline stall (hold) and flush (bubble) and includes an optional retired-instruction counter for the performance harness.

## Interface
Parameters:
- `RESET_PC_TAG`, default 32'h0000_0000: value loaded into `MEM_WB_ALUResult` on reset. Debug visibility only.

Ports:
- `Clk`  input  1  core clock; all state updates on the rising edge.
- `Rst`  input  1  asynchronous, active-low reset.
- `MEM_Stall`  input  1  hold all MEM/WB state this cycle.
- `MEM_Flush`  input  1  load a bubble this cycle.
- `EX_MEM_Valid`  input  1  the instruction in MEM is real, not a bubble.
- `EX_MEM_ALUResult`  input  32  ALU result or effective address.
- `MEM_ReadData`  input  32  load data from the data memory, already extended to 32 bits.
- `EX_MEM_MemToReg`  input  1  1 selects load data for writeback; 0 selects the ALU result.
- `EX_MEM_RegWrite`  input  1  the instruction writes the register file.
- `EX_MEM_WriteReg`  input  5  destination register index.
- `WB_CountClr`  input  1  synchronous clear of the retire counter.
- `MEM_WB_WriteData`  output  32  register-file write data.
- `MEM_WB_WriteReg`  output  5  register-file write index.
- `MEM_WB_RegWrite`  output  1  qualified register-file write enable.
- `MEM_WB_Valid`  output  1  the WB slot holds a real instruction.
- `MEM_WB_ALUResult`  output  32  registered ALU result, used for forwarding and debug.
- `WB_RetireCount`  output  32  retired-instruction count.

## Operation
- Priority on each edge is reset, then `MEM_Flush`, then `MEM_Stall`, then normal capture.
- **Normal capture:**
  - `MEM_WB_WriteData` is `EX_MEM_MemToReg ? MEM_ReadData : EX_MEM_ALUResult`, and the mux sits before the register.
  - `MEM_WB_WriteReg` takes `EX_MEM_WriteReg`.
  - `MEM_WB_ALUResult` takes `EX_MEM_ALUResult`.
  - `MEM_WB_Valid` takes `EX_MEM_Valid`.
  - `MEM_WB_RegWrite` is `EX_MEM_RegWrite & EX_MEM_Valid & (EX_MEM_WriteReg != 0)`. Writes to $zero are never emitted.
- **Stall:** every register holds its value, and the counter does not increment.
- **Flush:**
  - `MEM_WB_Valid` and `MEM_WB_RegWrite` go to 0.
  - Data, index and ALU-result registers are loaded with 0.
  - Flush wins over a simultaneous stall.
- **Retire counter:**
  - Increments by 1 on every normal-capture edge where `EX_MEM_Valid=1`.
  - Wraps from 32'hFFFF_FFFF to 0.
  - `WB_CountClr` sets it to 0. Clear beats increment on the same edge, and clear works during stall and flush.
- Implicit two-state machine on `MEM_WB_Valid`:
  - EMPTY to FULL on a capture with `EX_MEM_Valid=1`.
  - FULL to EMPTY on a flush, or on a capture with `EX_MEM_Valid=0`.
  - Stall holds the current state.

## Timing
- Latency: inputs are sampled at edge N and appear on the outputs after edge N, for the WB write in cycle N+1.
- All outputs are registered, with no combinational input-to-output path.
- Reset (`Rst`=0, asynchronous, independent of `Clk`):
  - `MEM_WB_WriteData`=0, `MEM_WB_WriteReg`=0, `MEM_WB_RegWrite`=0, `MEM_WB_Valid`=0.
  - `MEM_WB_ALUResult`=`RESET_PC_TAG`, `WB_RetireCount`=0.
- Reset asserted mid-stall or mid-flush overrides both immediately.
- Release is synchronous to the next edge: the first capture happens on the first rising edge with `Rst`=1.
- `MEM_Stall` and `MEM_Flush` are level signals, sampled only at the edge.

## Configuration
- `MEMWB_RETIRE_CNT_EN` defined:
  - The 32-bit retire counter and the `WB_CountClr` logic are built.
- Not defined:
  - `WB_RetireCount` is tied to 32'h0.
  - `WB_CountClr` is ignored.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- Reset, ALU path, load path:
  - Hold `Rst`=0 for 3 cycles: all outputs match the reset values, and `MEM_WB_ALUResult`=`RESET_PC_TAG`.
  - Release and drive ALUResult=32'h0000_1234, MemToReg=0, RegWrite=1, WriteReg=5, Valid=1: after one edge, WriteData=32'h1234, WriteReg=5, RegWrite=1, Valid=1.
  - With MemToReg=1 and ReadData=32'hDEAD_BEEF: WriteData=32'hDEAD_BEEF.
- $zero suppression: RegWrite=1, WriteReg=0, Valid=1 gives MEM_WB_RegWrite=0 and Valid=1. The counter still increments.
- Stall, then flush:
  - Capture WriteReg=7, then assert `MEM_Stall` for 3 edges while the inputs change: outputs stay at WriteReg=7 and the counter is unchanged.
  - Assert `MEM_Flush` together with `MEM_Stall`: Valid=0, RegWrite=0, WriteData=0 after that edge.
- Counter wrap and clear (macro defined):
  - Force the count to 32'hFFFF_FFFF and capture one valid instruction: count=0.
  - Assert `WB_CountClr` together with a valid capture: count=0.
- Async reset mid-operation:
  - Assert `Rst` low between edges while Valid=1: outputs reach the reset values before the next edge.
  - Rebuild without the macro: `WB_RetireCount` stays 0 across 10 valid captures.
